// File: rtl/timer_irq.sv
// timer_irq: 32-bit down-counting timer with one-shot / periodic interrupt, bus-mapped CTRL/PRESET/COUNT.
// Latency: EN set at edge t -> COUNT=PRESET after t+2, irq_flag after t+PRESET+2; rdata is combinational.
// Backpressure: none; bus writes always accepted in the cycle we=1.
// Ports: clk, reset (sync, active-high); addr/we/wdata bus write; rdata read data; irq = irq_flag & IM.
module timer_irq (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        en_q, en_d;
  logic [1:0]  mode_q, mode_d;
  logic        im_q, im_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        flag_q, flag_d;

  logic wr_ctrl;
  logic wr_preset;
  logic periodic;
  logic int_entry;

  assign wr_ctrl   = we && (addr == 2'd0);
  assign wr_preset = we && (addr == 2'd1);
  // Only MODE=1 is periodic; 2 and 3 fall back to one-shot.
  assign periodic  = (mode_q == 2'd1);

  always_comb begin
    state_d   = state_q;
    en_d      = en_q;
    mode_d    = mode_q;
    im_d      = im_q;
    preset_d  = preset_q;
    count_d   = count_q;
    flag_d    = flag_q;
    int_entry = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (en_q) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (!en_q) begin
          state_d = ST_IDLE;
        end else if (count_q <= 32'd1) begin
          // Covers PRESET=0 too: it expires on the same cycle as PRESET=1.
          count_d   = 32'd0;
          state_d   = ST_INT;
          int_entry = 1'b1;
        end else begin
          count_d = count_q - 32'd1;
        end
      end
      ST_INT: begin
        state_d = periodic ? ST_LOAD : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Flag priority, lowest first: bus clear, periodic one-cycle drop, expiry set.
    if (wr_ctrl || wr_preset) flag_d = 1'b0;
    if ((state_q == ST_INT) && periodic) flag_d = 1'b0;
    if (int_entry) flag_d = 1'b1;

    // One-shot expiry disables the timer, but a simultaneous CTRL write wins.
    if (int_entry && !periodic) en_d = 1'b0;
    if (wr_ctrl) begin
      en_d   = wdata[0];
      mode_d = wdata[2:1];
      im_d   = wdata[3];
    end

    if (wr_preset) preset_d = wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      en_q     <= 1'b0;
      mode_q   <= 2'd0;
      im_q     <= 1'b0;
      preset_q <= 32'd0;
      count_q  <= 32'd0;
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      mode_q   <= mode_d;
      im_q     <= im_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      flag_q   <= flag_d;
    end
  end

  always_comb begin
    rdata = 32'd0;
    case (addr)
      2'd0:    rdata = {28'd0, im_q, mode_q, en_q};
      2'd1:    rdata = preset_q;
      2'd2:    rdata = count_q;
      default: rdata = 32'd0;
    endcase
  end

  assign irq = flag_q & im_q;

endmodule

// File: tb/tb_timer_irq.sv
// tb_timer_irq: directed bench for timer_irq, one task per scenario.
// Inputs change 2-3 time units after a rising edge; outputs are read before the next edge.
module tb_timer_irq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  addr = 2'd0;
  logic        we = 1'b0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        irq;

  int total = 0;
  int bad = 0;

  timer_irq dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Write lands on the next rising edge.
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    @(posedge clk);
    #2;
    we = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    addr = a;
    #1;
    d = rdata;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    step(1);
    reset = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] v;
    reset = 1'b1;
    wr(2'd0, 32'hF);   // reset must beat this write
    wr(2'd1, 32'h55);
    reset = 1'b0;
    rd(2'd0, v); total++; if (v !== 32'd0) begin bad++; $display("FAIL reset_ctrl got=%0h exp=0", v); end
    rd(2'd1, v); total++; if (v !== 32'd0) begin bad++; $display("FAIL reset_preset got=%0h exp=0", v); end
    rd(2'd2, v); total++; if (v !== 32'd0) begin bad++; $display("FAIL reset_count got=%0h exp=0", v); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", irq); end
  endtask

  task automatic test_oneshot;
    logic [31:0] v;
    do_reset();
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);   // edge t
    step(2);
    rd(2'd2, v); total++; if (v !== 32'd5) begin bad++; $display("FAIL oneshot_count_t2 got=%0d exp=5", v); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL oneshot_irq_t2 got=%b exp=0", irq); end
    for (int k = 1; k <= 5; k++) begin
      step(1);
      rd(2'd2, v); total++;
      if (v !== 32'(5 - k)) begin bad++; $display("FAIL oneshot_count k=%0d got=%0d exp=%0d", k, v, 5 - k); end
      total++;
      if (irq !== (k == 5)) begin bad++; $display("FAIL oneshot_irq k=%0d got=%b exp=%b", k, irq, (k == 5)); end
    end
    rd(2'd0, v); total++; if (v !== 32'h8) begin bad++; $display("FAIL oneshot_ctrl got=%0h exp=8", v); end
    step(4);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL oneshot_irq_hold got=%b exp=1", irq); end
    wr(2'd0, 32'h0);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL oneshot_irq_clear got=%b exp=0", irq); end
  endtask

  task automatic test_periodic;
    logic [31:0] v;
    logic        exp;
    do_reset();
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);   // edge t
    for (int k = 1; k <= 16; k++) begin
      step(1);
      exp = (k >= 5) && ((k % 5) == 0);
      total++;
      if (irq !== exp) begin bad++; $display("FAIL periodic_irq k=%0d got=%b exp=%b", k, irq, exp); end
    end
    rd(2'd0, v); total++; if (v !== 32'hB) begin bad++; $display("FAIL periodic_ctrl got=%0h exp=b", v); end
  endtask

  task automatic test_pause;
    logic [31:0] v;
    do_reset();
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h9);   // edge t
    step(5);
    rd(2'd2, v); total++; if (v !== 32'd7) begin bad++; $display("FAIL pause_count_t5 got=%0d exp=7", v); end
    wr(2'd0, 32'h8);   // EN=0 on the edge where COUNT becomes 6
    step(3);
    rd(2'd2, v); total++; if (v !== 32'd6) begin bad++; $display("FAIL pause_count_hold got=%0d exp=6", v); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL pause_irq got=%b exp=0", irq); end
    total++; if (dut.state_q !== 2'd0) begin bad++; $display("FAIL pause_state got=%0d exp=0", dut.state_q); end
    wr(2'd0, 32'h9);   // edge u
    step(1);
    rd(2'd2, v); total++; if (v !== 32'd6) begin bad++; $display("FAIL pause_count_load got=%0d exp=6", v); end
    step(1);
    rd(2'd2, v); total++; if (v !== 32'd10) begin bad++; $display("FAIL pause_count_reload got=%0d exp=10", v); end
  endtask

  task automatic test_mask;
    logic [31:0] v;
    do_reset();
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h1);   // edge t, IM=0
    step(4);           // INT entered at t+4
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL mask_irq_masked got=%b exp=0", irq); end
    rd(2'd0, v); total++; if (v !== 32'h0) begin bad++; $display("FAIL mask_ctrl_en_clr got=%0h exp=0", v); end
    wr(2'd0, 32'h8);   // IM=1 write clears the pending flag
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL mask_irq_after_write got=%b exp=0", irq); end
    wr(2'd0, 32'h1);   // edge t'
    step(3);
    wr(2'd0, 32'h8);   // coincides with INT entry at t'+4
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL mask_irq_coincide got=%b exp=1", irq); end
    rd(2'd0, v); total++; if (v !== 32'h8) begin bad++; $display("FAIL mask_ctrl got=%0h exp=8", v); end
    step(2);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL mask_irq_hold got=%b exp=1", irq); end
  endtask

  task automatic test_ctrl_race;
    logic [31:0] v;
    do_reset();
    wr(2'd1, 32'd1);
    wr(2'd0, 32'h1);   // edge t
    step(2);
    wr(2'd0, 32'h9);   // edge t+3 = INT entry with hardware EN clear
    rd(2'd0, v); total++; if (v !== 32'h9) begin bad++; $display("FAIL race_ctrl got=%0h exp=9", v); end
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL race_irq got=%b exp=1", irq); end
  endtask

  task automatic test_preset0;
    logic [31:0] v;
    do_reset();
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h9);   // edge t
    step(2);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL p0_irq_t2 got=%b exp=0", irq); end
    rd(2'd2, v); total++; if (v !== 32'd0) begin bad++; $display("FAIL p0_count got=%0d exp=0", v); end
    step(1);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL p0_irq_t3 got=%b exp=1", irq); end
  endtask

  task automatic test_bus_ignore;
    logic [31:0] v;
    do_reset();
    wr(2'd1, 32'd20);
    wr(2'd0, 32'h1);   // edge t
    step(2);
    rd(2'd2, v); total++; if (v !== 32'd20) begin bad++; $display("FAIL ign_count_t2 got=%0d exp=20", v); end
    wr(2'd2, 32'h1234);
    rd(2'd2, v); total++; if (v !== 32'd19) begin bad++; $display("FAIL ign_count_addr2 got=%0d exp=19", v); end
    wr(2'd3, 32'h1234);
    rd(2'd2, v); total++; if (v !== 32'd18) begin bad++; $display("FAIL ign_count_addr3 got=%0d exp=18", v); end
    wr(2'd1, 32'd7);   // PRESET change mid-count
    rd(2'd2, v); total++; if (v !== 32'd17) begin bad++; $display("FAIL ign_count_preset got=%0d exp=17", v); end
    rd(2'd3, v); total++; if (v !== 32'd0) begin bad++; $display("FAIL ign_addr3_read got=%0h exp=0", v); end
    rd(2'd1, v); total++; if (v !== 32'd7) begin bad++; $display("FAIL ign_preset_read got=%0d exp=7", v); end
    wr(2'd0, 32'h0);
    step(1);
    wr(2'd0, 32'h1);   // edge u
    step(2);
    rd(2'd2, v); total++; if (v !== 32'd7) begin bad++; $display("FAIL ign_new_preset got=%0d exp=7", v); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] v;
    do_reset();
    wr(2'd1, 32'd9);
    wr(2'd0, 32'h9);   // edge t
    step(4);
    rd(2'd2, v); total++; if (v !== 32'd7) begin bad++; $display("FAIL rmid_count_pre got=%0d exp=7", v); end
    reset = 1'b1;
    wr(2'd0, 32'hF);   // reset dominates this write
    reset = 1'b0;
    rd(2'd0, v); total++; if (v !== 32'd0) begin bad++; $display("FAIL rmid_ctrl got=%0h exp=0", v); end
    rd(2'd1, v); total++; if (v !== 32'd0) begin bad++; $display("FAIL rmid_preset got=%0h exp=0", v); end
    rd(2'd2, v); total++; if (v !== 32'd0) begin bad++; $display("FAIL rmid_count got=%0h exp=0", v); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL rmid_irq got=%b exp=0", irq); end
    total++; if (dut.state_q !== 2'd0) begin bad++; $display("FAIL rmid_state got=%0d exp=0", dut.state_q); end
    step(3);
    rd(2'd2, v); total++; if (v !== 32'd0) begin bad++; $display("FAIL rmid_count_idle got=%0h exp=0", v); end
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_periodic();
    test_pause();
    test_mask();
    test_ctrl_race();
    test_preset0();
    test_bus_ignore();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/timer_irq.md
TIMER_IRQ -- requirements
Module: timer_irq

Interface
REQ-001 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port reset  input  1  synchronous, active-high; clock clk.
REQ-003 SHALL have port addr  input  2  word offset: 0=CTRL, 1=PRESET, 2=COUNT, 3=reserved.
REQ-004 SHALL have port we  input  1  bus write strobe; write occurs at the rising edge where we=1.
REQ-005 SHALL have port wdata  input  32  bus write data.
REQ-006 SHALL have port rdata  output  32  combinational read data for addr.
REQ-007 SHALL have port irq  output  1  level interrupt request to the CPU's HWInt input.
REQ-008 SHALL have parameter-free CTRL layout: bit0 EN, bits2:1 MODE, bit3 IM (interrupt mask); bits31:4 read as 0.

Function
REQ-009 SHALL implement FSM states IDLE, LOAD, CNT, INT, held in a registered state variable.
REQ-010 IDLE: EN=1 -> LOAD at next edge; else stay.
REQ-011 LOAD: COUNT <= PRESET; -> CNT.
REQ-012 CNT, EN=0: -> IDLE; COUNT holds.
REQ-013 CNT, EN=1, COUNT<=1: COUNT <= 0; -> INT.
REQ-014 CNT, EN=1, COUNT>1: COUNT <= COUNT-1; stay in CNT.
REQ-015 On entering INT in MODE=0 (one-shot), hardware SHALL clear CTRL.EN and set irq_flag; INT -> IDLE.
REQ-016 On entering INT in MODE=1 (periodic), hardware SHALL set irq_flag for exactly the one cycle spent in INT; INT -> LOAD.
REQ-017 MODE values 2 and 3 SHALL behave as MODE=0.
REQ-018 Mode-0 irq_flag SHALL remain 1 until a bus write to CTRL or PRESET.
REQ-019 irq SHALL equal irq_flag AND CTRL.IM (combinational; IM=0 masks without clearing irq_flag).
REQ-020 Timing: with EN written 1 at edge t and PRESET=N>=1, COUNT=N after edge t+2; irq first rises after edge t+N+2.
REQ-021 PRESET=0 SHALL behave as PRESET=1.
REQ-022 Bus writes: addr 0 -> CTRL <= wdata[3:0]; addr 1 -> PRESET <= wdata; addr 2 and 3 SHALL be ignored (COUNT read-only).
REQ-023 A PRESET write during CNT SHALL NOT alter COUNT; it takes effect at the next LOAD.
REQ-024 Clearing EN then setting it again SHALL restart from PRESET via LOAD (no resume).
REQ-025 A CTRL bus write in the same cycle as the hardware EN clear (REQ-015) SHALL win for CTRL contents.
REQ-026 When INT entry and a clearing bus write (REQ-018) coincide, irq_flag SHALL end set (event not lost).
REQ-027 rdata SHALL be {28'b0,IM,MODE,EN} for addr 0, PRESET for 1, COUNT for 2, 0 for 3, independent of we.
REQ-028 COUNT arithmetic SHALL be 32-bit unsigned with no underflow below 0.

Reset
REQ-029 On reset=1 at an edge: state=IDLE, CTRL=0, PRESET=0, COUNT=0, irq_flag=0; irq=0 and rdata reflects zeros the following cycle.
REQ-030 Reset SHALL dominate bus writes and FSM transitions in the same cycle, including mid-count and in INT.

Verification
REQ-031 PRESET=5, CTRL=0b1001 (IM=1, MODE=0, EN=1) -> COUNT reads 5,4,3,2,1,0; irq=1 from edge t+7; CTRL reads 0b1000; irq stays 1 until CTRL written 0.
REQ-032 PRESET=3, CTRL=0b1011 (MODE=1) -> irq one-cycle pulse every 5 cycles (LOAD+3 CNT+INT), EN remains 1.
REQ-033 PRESET=10, EN=1, clear EN after COUNT=6 -> FSM IDLE, COUNT holds 6, irq never rises; set EN again -> COUNT reloads 10.
REQ-034 MODE=0, IM=0 -> irq stays 0 while irq_flag sets; writing IM=1 (EN=0) -> write clears flag, irq stays 0; repeat with write coinciding with INT entry -> irq=1.
REQ-035 Write 0x1234 to addr 2 and 3 during CNT -> COUNT unaffected; addr 3 reads 0.
REQ-036 Assert reset while in CNT with COUNT=7 -> next cycle all registers 0, state IDLE, irq=0.
